// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states, iteration count.
// Combinational helpers only; no timing or backpressure of its own.
package mdu_pkg;

   localparam int ITER  = 32;
   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      MDU_MULTU = 2'b00,
      MDU_MULT  = 2'b01,
      MDU_DIVU  = 2'b10,
      MDU_DIV   = 2'b11
   } mdu_op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_FINISH = 2'd2
   } mdu_state_e;

   function automatic logic op_is_signed(input mdu_op_e o);
      return (o == MDU_MULT) || (o == MDU_DIV);
   endfunction

   function automatic logic op_is_div(input mdu_op_e o);
      return (o == MDU_DIVU) || (o == MDU_DIV);
   endfunction

endpackage

// File: rtl/mdu_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
// Latency: purely combinational. Backpressure: none.
module mdu_negate #(
   parameter int W = 32
) (
   input  logic         neg,
   input  logic [W-1:0] val,
   output logic [W-1:0] res
);

   assign res = neg ? (~val + W'(1)) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide (one bit per clock) writing HI/LO, for the execute stage.
// Latency: fixed 33 edges start-to-result. Backpressure: busy stalls control; start ignored while busy.
module mult_div_unit
   import mdu_pkg::*;
#(
   parameter int WIDTH = ITER
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   mdu_state_e       state, state_nxt;
   logic             load_en, iter_en, fin_en;
   logic             last_iter;
   logic [CNT_W-1:0] count;

   mdu_op_e          op_in, op_q;
   logic             in_signed;
   logic             sign_a, sign_b, dz_q;
   logic [WIDTH-1:0] mag_a, mag_b;

   // acc_hi: product upper half / partial remainder; acc_lo: multiplier / quotient
   logic [WIDTH-1:0] acc_hi, acc_lo, opnd_q;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   sh_rem;
   logic [WIDTH:0]   trial;

   logic [2*WIDTH-1:0] prod_raw, prod_fix;
   logic [WIDTH-1:0]   quot_fix, rem_fix;
   logic               neg_prod, neg_quot, neg_rem;

   assign op_in     = mdu_op_e'(op);
   assign in_signed = op_is_signed(op_in);
   assign last_iter = (count == CNT_W'(WIDTH-1));

   // ---------------- FSM ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start)     state_nxt = S_RUN;
         S_RUN:    if (last_iter) state_nxt = S_FINISH;
         S_FINISH:                state_nxt = S_IDLE;
         default:                 state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      load_en = 1'b0;
      iter_en = 1'b0;
      fin_en  = 1'b0;
      case (state)
         S_IDLE:   load_en = start;
         S_RUN:    iter_en = 1'b1;
         S_FINISH: fin_en  = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        count <= '0;
      else if (load_en) count <= '0;
      else if (iter_en) count <= count + CNT_W'(1);
   end

   // ---------------- operand load ----------------
   mdu_negate #(.W(WIDTH)) u_mag_a (
      .neg (in_signed & operand_a[WIDTH-1]),
      .val (operand_a),
      .res (mag_a)
   );

   mdu_negate #(.W(WIDTH)) u_mag_b (
      .neg (in_signed & operand_b[WIDTH-1]),
      .val (operand_b),
      .res (mag_b)
   );

   // ---------------- iteration datapath ----------------
   assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign sh_rem  = {acc_hi, acc_lo[WIDTH-1]};
   assign trial   = sh_rem - {1'b0, opnd_q};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= MDU_MULTU;
         sign_a <= 1'b0;
         sign_b <= 1'b0;
         dz_q   <= 1'b0;
         acc_hi <= '0;
         acc_lo <= '0;
         opnd_q <= '0;
      end else if (load_en) begin
         op_q   <= op_in;
         sign_a <= in_signed & operand_a[WIDTH-1];
         sign_b <= in_signed & operand_b[WIDTH-1];
         dz_q   <= op_is_div(op_in) && (operand_b == '0);
         acc_hi <= '0;
         if (op_is_div(op_in)) begin
            acc_lo <= mag_a;
            opnd_q <= mag_b;
         end else begin
            acc_lo <= mag_b;
            opnd_q <= mag_a;
         end
      end else if (iter_en) begin
         if (op_is_div(op_q)) begin
            // Restoring step: a clear sign bit means the divisor fits this round
            if (!trial[WIDTH]) begin
               acc_hi <= trial[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi <= sh_rem[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
            end
         end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
         end
      end
   end

   // ---------------- sign fix ----------------
   assign prod_raw = {acc_hi, acc_lo};
   assign neg_prod = (op_q == MDU_MULT) && (sign_a ^ sign_b);
   assign neg_quot = (op_q == MDU_DIV)  && (sign_a ^ sign_b);
   assign neg_rem  = (op_q == MDU_DIV)  && sign_a;

   mdu_negate #(.W(2*WIDTH)) u_fix_prod (
      .neg (neg_prod),
      .val (prod_raw),
      .res (prod_fix)
   );

   mdu_negate #(.W(WIDTH)) u_fix_quot (
      .neg (neg_quot),
      .val (acc_lo),
      .res (quot_fix)
   );

   // With a zero divisor the remainder ends up as |a|, so this restores a unchanged
   mdu_negate #(.W(WIDTH)) u_fix_rem (
      .neg (neg_rem),
      .val (acc_hi),
      .res (rem_fix)
   );

   // ---------------- result / status registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done <= fin_en;
         if (load_en) begin
            busy        <= 1'b1;
            div_by_zero <= 1'b0;
         end
         if (fin_en) begin
            busy        <= 1'b0;
            div_by_zero <= dz_q;
            if (op_is_div(op_q)) begin
               hi <= rem_fix;
               lo <= dz_q ? {WIDTH{1'b1}} : quot_fix;
            end else begin
               hi <= prod_fix[2*WIDTH-1:WIDTH];
               lo <= prod_fix[WIDTH-1:0];
            end
         end
      end
   end

endmodule
